// File: rtl/tnoc_axi_write_read_arbiter.sv
// Merges the write-response and read-response flit streams onto one output,
// locking on a packet until its tail and bounding read bursts while a write waits.
module tnoc_axi_write_read_arbiter #(
    parameter int FLIT_WIDTH     = 64,
    parameter int MAX_READ_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_write_valid,
    output logic                  o_write_ready,
    input  logic [FLIT_WIDTH-1:0] i_write_flit,
    input  logic                  i_write_tail,
    input  logic                  i_read_valid,
    output logic                  o_read_ready,
    input  logic [FLIT_WIDTH-1:0] i_read_flit,
    input  logic                  i_read_tail,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [FLIT_WIDTH-1:0] o_flit,
    output logic                  o_tail
);

    typedef enum logic [1:0] {IDLE, WRITE_LOCK, READ_LOCK} state_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_READ_BURST);

    state_e                  state_q, state_d;
    logic [3:0]              burst_cnt_q, burst_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;
    logic                    out_tail_q, out_tail_d;
    logic                    grant_write, grant_read;
    logic                    slot_free;
    logic                    write_xfer, read_xfer;

    // Grant decode: IDLE arbitrates on the live valids, LOCK states hold the owner.
    always_comb begin
        grant_write = 1'b0;
        grant_read  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_write_valid && (!i_read_valid || burst_cnt_q == BURST_MAX))
                    grant_write = 1'b1;
                else if (i_read_valid)
                    grant_read = 1'b1;
            end
            WRITE_LOCK: grant_write = 1'b1;
            READ_LOCK:  grant_read  = 1'b1;
            default: ;
        endcase
    end

    assign slot_free     = !out_valid_q || i_ready;
    // Readies are gated by reset so they drop in the same cycle reset asserts.
    assign o_write_ready = i_rst_n && grant_write && slot_free;
    assign o_read_ready  = i_rst_n && grant_read && slot_free;
    assign write_xfer    = i_write_valid && o_write_ready;
    assign read_xfer     = i_read_valid && o_read_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_xfer && !i_write_tail)
                    state_d = WRITE_LOCK;
                else if (read_xfer && !i_read_tail)
                    state_d = READ_LOCK;
            end
            WRITE_LOCK: if (write_xfer && i_write_tail) state_d = IDLE;
            READ_LOCK:  if (read_xfer && i_read_tail)   state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Reads only count toward the burst limit while a write is actually waiting.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (write_xfer && i_write_tail) begin
            burst_cnt_d = '0;
        end else if (read_xfer && i_read_tail) begin
            if (!i_write_valid)
                burst_cnt_d = '0;
            else if (burst_cnt_q != BURST_MAX)
                burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_tail_d  = out_tail_q;
        if (write_xfer) begin
            out_valid_d = 1'b1;
            out_flit_d  = i_write_flit;
            out_tail_d  = i_write_tail;
        end else if (read_xfer) begin
            out_valid_d = 1'b1;
            out_flit_d  = i_read_flit;
            out_tail_d  = i_read_tail;
        end else if (i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_tail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_tail_q  <= out_tail_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_flit  = out_flit_q;
    assign o_tail  = out_tail_q;

endmodule

// File: tb/tb_tnoc_axi_write_read_arbiter.sv
// Scenario bench for the write/read merge arbiter: source queues feed the DUT,
// expected output flits are queued per scenario and checked as they leave.
module tb_tnoc_axi_write_read_arbiter;

    typedef struct packed {
        logic        tail;
        logic [63:0] flit;
    } flit_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_write_valid = 1'b0, i_write_tail = 1'b0;
    logic        i_read_valid = 1'b0, i_read_tail = 1'b0;
    logic [63:0] i_write_flit = '0, i_read_flit = '0;
    logic        i_ready = 1'b0;
    logic        o_write_ready, o_read_ready, o_valid, o_tail;
    logic [63:0] o_flit;

    flit_t wq[$];
    flit_t rq[$];
    flit_t exp_q[$];
    flit_t mon_e;
    bit    w_en = 1'b1, r_en = 1'b1;
    bit    w_fire, r_fire;
    int    total = 0;
    int    bad = 0;

    tnoc_axi_write_read_arbiter #(.FLIT_WIDTH(64), .MAX_READ_BURST(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_write_valid(i_write_valid), .o_write_ready(o_write_ready),
        .i_write_flit(i_write_flit), .i_write_tail(i_write_tail),
        .i_read_valid(i_read_valid), .o_read_ready(o_read_ready),
        .i_read_flit(i_read_flit), .i_read_tail(i_read_tail),
        .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit), .o_tail(o_tail)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic drive_inputs();
        i_write_valid = w_en && (wq.size() != 0);
        i_write_flit  = (wq.size() != 0) ? wq[0].flit : '0;
        i_write_tail  = (wq.size() != 0) ? wq[0].tail : 1'b0;
        i_read_valid  = r_en && (rq.size() != 0);
        i_read_flit   = (rq.size() != 0) ? rq[0].flit : '0;
        i_read_tail   = (rq.size() != 0) ? rq[0].tail : 1'b0;
    endtask

    // Source driver and output scoreboard: sample at negedge, advance after posedge.
    initial forever begin
        @(negedge i_clk);
        w_fire = i_write_valid && o_write_ready;
        r_fire = i_read_valid && o_read_ready;
        if (w_fire || r_fire) begin
            total++;
            if (w_fire && r_fire) begin
                bad++;
                $display("FAIL dual_accept: got both readies accepted, want one");
            end
        end
        if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got %0b/%0h want no flit", o_tail, o_flit);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_tail, o_flit} !== mon_e) begin
                    bad++;
                    $display("FAIL out_flit: got %0b/%0h want %0b/%0h", o_tail, o_flit, mon_e.tail, mon_e.flit);
                end
            end
        end
        @(posedge i_clk);
        #1;
        if (w_fire) void'(wq.pop_front());
        if (r_fire) void'(rq.pop_front());
        drive_inputs();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #3 i_rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", o_valid); end
        total++; if ({o_flit, o_tail} !== 65'd0) begin bad++; $display("FAIL rst_data: got %0h want 0", o_flit); end
        wq.push_back('{tail: 1'b1, flit: 64'hdead});
        rq.push_back('{tail: 1'b1, flit: 64'hbeef});
        drive_inputs();
        #1;
        total++; if (o_write_ready !== 1'b0) begin bad++; $display("FAIL rst_wready: got %0b want 0", o_write_ready); end
        total++; if (o_read_ready !== 1'b0) begin bad++; $display("FAIL rst_rready: got %0b want 0", o_read_ready); end
        @(posedge i_clk); #2;
        wq.delete(); rq.delete(); drive_inputs();
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
    endtask

    task automatic test_write_packet();
        @(posedge i_clk); #2;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{tail: (i == 2), flit: 64'h1000 + 64'(i)});
            exp_q.push_back('{tail: (i == 2), flit: 64'h1000 + 64'(i)});
        end
        drive_inputs();
        for (int c = 0; c <= 4; c++) begin
            @(negedge i_clk);
            total++; if (o_valid !== (c >= 1 && c <= 3)) begin bad++; $display("FAIL wr_valid c%0d: got %0b want %0b", c, o_valid, (c >= 1 && c <= 3)); end
            total++; if (o_read_ready !== 1'b0) begin bad++; $display("FAIL wr_rready c%0d: got %0b want 0", c, o_read_ready); end
            if (c == 3) begin
                total++; if (o_tail !== 1'b1) begin bad++; $display("FAIL wr_tail: got %0b want 1", o_tail); end
            end
            if (c < 4) begin @(posedge i_clk); #2; end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wr_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_burst();
        int ri = 0, wi = 0;
        @(posedge i_clk); #2;
        for (int i = 0; i < 8; i++) rq.push_back('{tail: 1'b1, flit: 64'h2000 + 64'(i)});
        for (int i = 0; i < 2; i++) wq.push_back('{tail: 1'b1, flit: 64'h1010 + 64'(i)});
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin exp_q.push_back('{tail: 1'b1, flit: 64'h1010 + 64'(wi)}); wi++; end
            else begin exp_q.push_back('{tail: 1'b1, flit: 64'h2000 + 64'(ri)}); ri++; end
        end
        drive_inputs();
        for (int c = 0; c <= 11; c++) begin
            @(negedge i_clk);
            total++; if (o_valid !== (c >= 1 && c <= 10)) begin bad++; $display("FAIL burst_valid c%0d: got %0b want %0b", c, o_valid, (c >= 1 && c <= 10)); end
            total++; if (o_write_ready !== (c == 4 || c == 9)) begin bad++; $display("FAIL burst_wready c%0d: got %0b want %0b", c, o_write_ready, (c == 4 || c == 9)); end
            if (c < 11) begin @(posedge i_clk); #2; end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL burst_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_lock();
        @(posedge i_clk); #2;
        for (int i = 0; i < 4; i++) begin
            rq.push_back('{tail: (i == 3), flit: 64'h2100 + 64'(i)});
            exp_q.push_back('{tail: (i == 3), flit: 64'h2100 + 64'(i)});
        end
        exp_q.push_back('{tail: 1'b1, flit: 64'h1100});
        drive_inputs();
        for (int c = 0; c <= 6; c++) begin
            if (c == 1) begin wq.push_back('{tail: 1'b1, flit: 64'h1100}); drive_inputs(); end
            @(negedge i_clk);
            total++; if (o_write_ready !== (c == 4)) begin bad++; $display("FAIL lock_wready c%0d: got %0b want %0b", c, o_write_ready, (c == 4)); end
            total++; if (o_read_ready !== (c <= 3)) begin bad++; $display("FAIL lock_rready c%0d: got %0b want %0b", c, o_read_ready, (c <= 3)); end
            total++; if (o_valid !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL lock_valid c%0d: got %0b want %0b", c, o_valid, (c >= 1 && c <= 5)); end
            if (c < 6) begin @(posedge i_clk); #2; end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lock_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        @(posedge i_clk); #2;
        for (int i = 0; i < 4; i++) begin
            wq.push_back('{tail: (i == 3), flit: 64'h1200 + 64'(i)});
            exp_q.push_back('{tail: (i == 3), flit: 64'h1200 + 64'(i)});
        end
        drive_inputs();
        for (int c = 0; c <= 10; c++) begin
            if (c == 1) i_ready = 1'b0;
            if (c == 6) i_ready = 1'b1;
            @(negedge i_clk);
            if (c >= 1 && c <= 5) begin
                total++; if (o_flit !== 64'h1200) begin bad++; $display("FAIL stall_flit c%0d: got %0h want 1200", c, o_flit); end
                total++; if ({o_write_ready, o_read_ready} !== 2'b00) begin bad++; $display("FAIL stall_ready c%0d: got %0b%0b want 00", c, o_write_ready, o_read_ready); end
            end else begin
                total++; if (o_write_ready !== (c <= 8)) begin bad++; $display("FAIL stall_wready c%0d: got %0b want %0b", c, o_write_ready, (c <= 8)); end
            end
            total++; if (o_valid !== (c >= 1 && c <= 9)) begin bad++; $display("FAIL stall_valid c%0d: got %0b want %0b", c, o_valid, (c >= 1 && c <= 9)); end
            if (c < 10) begin @(posedge i_clk); #2; end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_bubble();
        @(posedge i_clk); #2;
        wq.push_back('{tail: 1'b1, flit: 64'h1300});
        for (int i = 0; i < 3; i++) begin
            rq.push_back('{tail: (i == 2), flit: 64'h2300 + 64'(i)});
            exp_q.push_back('{tail: (i == 2), flit: 64'h2300 + 64'(i)});
        end
        exp_q.push_back('{tail: 1'b1, flit: 64'h1300});
        drive_inputs();
        for (int c = 0; c <= 6; c++) begin
            if (c == 1) begin r_en = 1'b0; drive_inputs(); end
            if (c == 2) begin r_en = 1'b1; drive_inputs(); end
            @(negedge i_clk);
            if (c == 0) begin
                total++; if (o_read_ready !== 1'b1) begin bad++; $display("FAIL bub_rgrant: got %0b want 1", o_read_ready); end
            end
            total++; if (o_write_ready !== (c == 4)) begin bad++; $display("FAIL bub_wready c%0d: got %0b want %0b", c, o_write_ready, (c == 4)); end
            total++; if (o_valid !== (c == 1 || (c >= 3 && c <= 5))) begin bad++; $display("FAIL bub_valid c%0d: got %0b want %0b", c, o_valid, (c == 1 || (c >= 3 && c <= 5))); end
            if (c < 6) begin @(posedge i_clk); #2; end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bub_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        @(posedge i_clk); #2;
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{tail: (i == 2), flit: 64'h1400 + 64'(i)});
            exp_q.push_back('{tail: (i == 2), flit: 64'h1400 + 64'(i)});
        end
        drive_inputs();
        @(posedge i_clk); #2;
        rq.push_back('{tail: 1'b1, flit: 64'h2400});
        drive_inputs();
        i_rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %0b want 0", o_valid); end
        total++; if ({o_write_ready, o_read_ready} !== 2'b00) begin bad++; $display("FAIL rmid_ready: got %0b%0b want 00", o_write_ready, o_read_ready); end
        wq.delete(); exp_q.delete(); drive_inputs();
        repeat (2) @(posedge i_clk);
        #2;
        wq.push_back('{tail: 1'b1, flit: 64'h1410});
        exp_q.push_back('{tail: 1'b1, flit: 64'h2400});
        exp_q.push_back('{tail: 1'b1, flit: 64'h1410});
        i_rst_n = 1'b1;
        drive_inputs();
        @(negedge i_clk);
        total++; if ({o_read_ready, o_write_ready} !== 2'b10) begin bad++; $display("FAIL rmid_grant: got r%0b w%0b want r1 w0", o_read_ready, o_write_ready); end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin @(negedge i_clk); #1; end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_packet();
        test_burst();
        test_lock();
        test_stall();
        test_bubble();
        test_reset_mid();
        repeat (2) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tnoc_axi_write_read_arbiter.md
TNOC_AXI_WRITE_READ_ARBITER -- requirements
Module: tnoc_axi_write_read_arbiter

Interface
REQ-001 Parameter FLIT_WIDTH, default 64, width of one flit word.
REQ-002 Parameter MAX_READ_BURST, default 4, range 1..15: maximum consecutive read packets granted while a write packet waits.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_write_valid  input  1  write-response flit valid.
REQ-006 o_write_ready  output  1  write-response flit accepted.
REQ-007 i_write_flit  input  FLIT_WIDTH  write-response flit.
REQ-008 i_write_tail  input  1  write flit is last of its packet.
REQ-009 i_read_valid / o_read_ready / i_read_flit / i_read_tail: same as REQ-005..008, read-response-with-data stream.
REQ-010 o_valid  output  1  merged flit valid.
REQ-011 i_ready  input  1  downstream accepts merged flit.
REQ-012 o_flit  output  FLIT_WIDTH  merged flit.
REQ-013 o_tail  output  1  merged flit is packet tail.

Function
REQ-014 A transfer occurs on an input when valid and ready are both high at a rising edge; same rule at the output.
REQ-015 Grant FSM states: IDLE, WRITE_LOCK, READ_LOCK.
REQ-016 In IDLE, the winner is selected combinationally and its head flit is accepted in the same cycle.
REQ-017 Selection in IDLE: only one valid -> that one; both valid -> read, unless the read-burst counter equals MAX_READ_BURST, then write.
REQ-018 IDLE -> WRITE_LOCK or READ_LOCK when a winner's non-tail flit transfers; a single-flit packet (tail on head) transfers and the FSM stays in IDLE.
REQ-019 In a LOCK state, only the locked input may have ready high; the other input's ready is low.
REQ-020 LOCK -> IDLE on transfer of the locked input's tail flit; next packet head may transfer the following cycle (no bubble).
REQ-021 Read-burst counter (4 bits): increments on each read tail transfer while i_write_valid is high; clears on any write tail transfer or on a read tail transfer with i_write_valid low; saturates at MAX_READ_BURST.
REQ-022 Output is a one-entry register slice: latency from input transfer to o_valid is exactly 1 cycle.
REQ-023 Input ready for the selected/locked input = (!o_valid || i_ready); full throughput of one flit per cycle is sustained.
REQ-024 o_flit and o_tail hold stable while o_valid high and i_ready low.
REQ-025 An input valid dropping mid-packet (bubble) keeps the lock; no other input is granted until the tail.
REQ-026 Ready of a non-selected input is never asserted; no flit is ever accepted from both inputs in one cycle.
REQ-027 Flits of one packet appear on the output contiguous and in order; packets are never interleaved.

Reset
REQ-028 On i_rst_n low: FSM = IDLE, burst counter = 0, o_valid = 0, o_write_ready = 0, o_read_ready = 0, immediately (asynchronous).
REQ-029 o_flit and o_tail are reset to 0.
REQ-030 Reset asserted mid-packet discards the partial packet and the output slice; after release, arbitration restarts from IDLE with counter 0.

Verification
REQ-031 Write-only 3-flit packet, i_ready=1 -> o_valid cycles 1..3 after head, o_tail on third flit, o_read_ready stays 0.
REQ-032 Both inputs with continuous 1-flit packets, MAX_READ_BURST=4 -> output order R,R,R,R,W,R,R,R,R,W.
REQ-033 Read 4-flit packet locked, write valid arrives on flit 2 -> o_write_ready 0 until cycle after read tail; write head follows read tail with no gap.
REQ-034 i_ready held 0 for 5 cycles with o_valid 1 -> o_flit stable, both input readies 0; on release, one flit per cycle resumes.
REQ-035 Read valid bubble on flit 2 of 3 while write waits -> write not granted until read tail transfers.
REQ-036 Reset asserted during flit 2 of a write packet -> o_valid and readies 0 same cycle; after release, a waiting read packet is granted first.
